// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues in-order word reads,
// buffers {instr, pc} in a small FIFO and flushes on redirect.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];

  logic          redir;
  logic          req_fire;
  logic          resp;
  logic          push;
  logic          pop;
  logic [CW:0]   credit;
  logic [CW-1:0] inflight_rem;
  logic [31:0]   redir_pc;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign redir_pc      = {redirect_pc[31:2], 2'b00};

  assign redir  = redirect_valid & (state_q != IDLE);
  assign credit = {1'b0, count_q} + {1'b0, inflight_q};

  assign imem_req_valid = (state_q == FETCH)
                        & (credit < (CW+1)'(DEPTH))
                        & ~redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp         = imem_resp_valid & (inflight_q != '0);
  assign inflight_rem = inflight_q - CW'(resp);

  assign push = resp & ~redir
              & (discard_q == '0)
              & (state_q == FETCH);

  assign out_valid = (count_q != '0);
  assign out_instr = instr_q[rd_ptr_q];
  assign out_pc    = pc_q[rd_ptr_q];
  assign pop       = out_valid & out_ready & ~redir;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    shadow_d   = shadow_q;
    count_d    = count_q;
    inflight_d = inflight_rem + CW'(req_fire);
    discard_d  = discard_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (redir) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redir_pc;
      shadow_d   = redir_pc;
      discard_d  = inflight_rem;
      state_d    = (inflight_rem != '0) ? DRAIN : FETCH;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp && discard_q != '0) begin
        discard_d = discard_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        shadow_d = shadow_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      unique case (state_q)
        IDLE:    state_d = FETCH;
        DRAIN:   if (discard_d == '0) state_d = FETCH;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      shadow_q   <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      shadow_q   <= shadow_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push) begin
        instr_q[wr_ptr_q] <= imem_resp_data;
        pc_q[wr_ptr_q]    <= shadow_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: in-order memory model with variable
// latency and a transaction-level queue model of the expected stream.
module tb_instr_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;

  instr_prefetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    int          due;
    bit          stale;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  pend_t       pq[$];
  ent_t        fq[$];
  logic [31:0] popped[$];
  logic [31:0] m_pc;
  int          cyc;
  int          nvec;
  int          nerr;
  int          nacc;
  int          ndrop;
  bit          last_req;
  bit          last_ov;
  bit          last_rsp;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  function automatic bit any_stale();
    foreach (pq[i]) if (pq[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    out_ready       = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    fq.delete();
    pq.delete();
    m_pc = 32'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit rdy, input bit ordy,
                      input bit redir, input logic [31:0] rpc,
                      input int lat, input bit rsp_ok);
    bit   rsp;
    ent_t e;
    cyc++;
    rsp = rsp_ok && pq.size() > 0 && pq[0].due <= cyc;
    imem_req_ready  = rdy;
    out_ready       = ordy;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    imem_resp_valid = rsp;
    imem_resp_data  = rsp ? mdata(pq[0].a) : $urandom;
    #1;
    last_req = imem_req_valid;
    last_ov  = out_valid;
    last_rsp = rsp;
    chk("out_valid", 32'(out_valid), 32'(fq.size() != 0));
    if (fq.size() != 0) begin
      chk("out_pc", out_pc, fq[0].pc);
      chk("out_instr", out_instr, fq[0].ins);
    end
    chk("req_in_redirect", 32'(imem_req_valid & redir), 0);
    chk("req_while_stale", 32'(imem_req_valid & any_stale()), 0);
    if (imem_req_valid) begin
      chk("req_addr", imem_req_addr, m_pc);
      chk("req_credit", 32'(fq.size() + pq.size() < DEPTH), 1);
    end
    if (fq.size() != 0 && ordy && !redir) begin
      popped.push_back(fq[0].pc);
      fq.delete(0);
    end
    if (rsp) begin
      if (!pq[0].stale && !redir) begin
        e.pc  = pq[0].a;
        e.ins = mdata(pq[0].a);
        fq.push_back(e);
      end else begin
        ndrop++;
      end
      pq.delete(0);
    end
    if (imem_req_valid && rdy) begin
      pq.push_back('{a: m_pc, due: cyc + lat, stale: 1'b0});
      m_pc = m_pc + 32'd4;
      nacc++;
    end
    if (redir) begin
      foreach (pq[i]) pq[i].stale = 1'b1;
      fq.delete();
      m_pc = {rpc[31:2], 2'b00};
    end
    @(negedge clk);
  endtask

  initial begin
    int pidx;
    int acc0;
    int drop0;
    int guard;
    logic [31:0] v;

    nvec = 0;
    nerr = 0;
    cyc  = 0;
    nacc = 0;
    ndrop = 0;

    // Throughput at 1-cycle latency.
    do_reset();
    step(1, 1, 0, 0, 1, 1);
    chk("idle_no_req", 32'(last_req), 0);
    step(1, 1, 0, 0, 1, 1);
    chk("first_req", 32'(last_req), 1);
    pidx = popped.size();
    repeat (10) step(1, 1, 0, 0, 1, 1);
    chk("thru_pops", popped.size() - pidx, 9);
    for (int i = 0; i < 6; i++) begin
      v = (popped.size() > pidx + i) ? popped[pidx + i] : 32'hDEAD_BEEF;
      chk("thru_pc", v, 32'(i * 4));
    end

    // Backpressure: credits cap outstanding work at DEPTH.
    do_reset();
    acc0 = nacc;
    repeat (10) step(1, 0, 0, 0, 1, 1);
    chk("stall_accepts", nacc - acc0, DEPTH);
    chk("stall_ov", 32'(last_ov), 1);
    pidx = popped.size();
    repeat (4) step(0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      v = (popped.size() > pidx + i) ? popped[pidx + i] : 32'hDEAD_BEEF;
      chk("stall_order", v, 32'(i * 4));
    end

    // Redirect with two in flight at 3-cycle latency.
    do_reset();
    step(1, 1, 0, 0, 3, 1);
    guard = 0;
    while (pq.size() < 2 && guard < 10) begin
      step(1, 1, 0, 0, 3, 1);
      guard++;
    end
    chk("two_inflight", pq.size(), 2);
    drop0 = ndrop;
    pidx  = popped.size();
    step(1, 1, 1, 32'h100, 3, 1);
    repeat (14) step(1, 1, 0, 0, 3, 1);
    chk("drain_drops", ndrop - drop0, 2);
    v = (popped.size() > pidx) ? popped[pidx] : 32'hDEAD_BEEF;
    chk("redir_first_pc", v, 32'h100);

    // Redirect near the top of the address space wraps.
    repeat (4) step(1, 1, 0, 0, 1, 1);
    pidx = popped.size();
    step(1, 1, 1, 32'hFFFF_FFFE, 1, 1);
    repeat (10) step(1, 1, 0, 0, 1, 1);
    v = (popped.size() > pidx) ? popped[pidx] : 32'hDEAD_BEEF;
    chk("wrap_pc0", v, 32'hFFFF_FFFC);
    v = (popped.size() > pidx + 1) ? popped[pidx + 1] : 32'hDEAD_BEEF;
    chk("wrap_pc1", v, 32'h0);

    // Redirect colliding with a pop and a response.
    repeat (6) step(1, 1, 0, 0, 1, 1);
    pidx  = popped.size();
    drop0 = ndrop;
    step(1, 1, 1, 32'h200, 1, 1);
    chk("coll_ov", 32'(last_ov), 1);
    chk("coll_rsp", 32'(last_rsp), 1);
    chk("coll_no_pop", popped.size() - pidx, 0);
    chk("coll_drop", ndrop - drop0, 1);
    step(0, 1, 0, 0, 1, 1);
    chk("coll_empty", 32'(last_ov), 0);
    repeat (6) step(1, 1, 0, 0, 1, 1);
    v = (popped.size() > pidx) ? popped[pidx] : 32'hDEAD_BEEF;
    chk("coll_next_pc", v, 32'h200);

    // Reset mid-stream with three entries queued.
    guard = 0;
    while (fq.size() != 3 && guard < 20) begin
      step(fq.size() < 3, 0, 0, 0, 1, 1);
      guard++;
    end
    chk("three_queued", fq.size(), 3);
    do_reset();
    step(1, 1, 0, 0, 1, 1);
    step(1, 1, 0, 0, 1, 1);
    chk("restart_req", 32'(last_req), 1);
    pidx = popped.size();
    repeat (4) step(1, 1, 0, 0, 1, 1);
    v = (popped.size() > pidx) ? popped[pidx] : 32'hDEAD_BEEF;
    chk("restart_pc", v, 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0,
           $urandom,
           $urandom_range(1, 4),
           $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
